// File: rtl/sdr_tuning_controller.sv
// sdr_tuning_controller
//   UART command interpreter for the 1-bit SDR receive chain. Owns the NCO
//   phase increment and CIC gain, supports presets, clamped tuning steps,
//   direct 64-bit hex frequency entry with a per-digit inactivity timeout,
//   and emits a K/E acknowledge byte toward a UART transmitter.
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   rx_valid, rx_byte  received byte strobe and data
//   tx_ready           transmitter accepts pending ack
//   tx_valid, tx_byte  pending ack ('K' = 8'h4B, 'E' = 8'h45)
//   phase_increment    NCO tuning word; phase_update pulses on each write
//   cic_gain           CIC gain select
//   cmd_error          one-cycle pulse on rejected/aborted command
module sdr_tuning_controller #(
  parameter int unsigned PHASE_WIDTH = 64,
  parameter int unsigned GAIN_WIDTH  = 8,
  parameter logic [63:0] DEFAULT_PHASE_INC = 64'h02C6A19E88F1CFE2,
  parameter logic [63:0] MAX_PHASE_INC     = 64'h7FFFFFFFFFFFFFFF,
  parameter logic [63:0] STEP_9K  = 64'h00071B375868D170,
  parameter logic [63:0] STEP_1K  = 64'h0000CA22980BA57E,
  parameter logic [63:0] STEP_100 = 64'h00001436A8CDF6F3,
  parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic                   phase_update,
  output logic [GAIN_WIDTH-1:0]  cic_gain,
  output logic                   cmd_error
);
  localparam int unsigned NDIG  = PHASE_WIDTH / 4;
  localparam int unsigned DIG_W = $clog2(NDIG + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PHASE_WIDTH-1:0] PMAX = PHASE_WIDTH'(MAX_PHASE_INC);
  localparam logic [7:0] ACK_K = 8'h4B;
  localparam logic [7:0] ACK_E = 8'h45;

  typedef enum logic [1:0] {IDLE, HEX, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d, shadow_q, shadow_d;
  logic [GAIN_WIDTH-1:0]  gain_q, gain_d;
  logic [DIG_W-1:0]       dig_q, dig_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic                   pu_q, pu_d, err_q, err_d, txv_q, txv_d;
  logic [7:0]             txb_q, txb_d;
  logic                   ack_set;
  logic [7:0]             ack_byte;

  logic [4:0] hex;   // {valid, nibble}
  logic       to_expired;

  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
      return {1'b1, b[3:0] + 4'd9};
    return 5'd0;
  endfunction

  // Steps are done one bit wider so overflow/underflow is visible and clamps
  // instead of wrapping.
  function automatic logic [PHASE_WIDTH-1:0] step_inc(
    input logic [PHASE_WIDTH-1:0] p, input logic [63:0] s);
    logic [PHASE_WIDTH:0] t;
    t = {1'b0, p} + {1'b0, PHASE_WIDTH'(s)};
    return (t > {1'b0, PMAX}) ? PMAX : t[PHASE_WIDTH-1:0];
  endfunction

  function automatic logic [PHASE_WIDTH-1:0] step_dec(
    input logic [PHASE_WIDTH-1:0] p, input logic [63:0] s);
    logic [PHASE_WIDTH:0] t;
    t = {1'b0, p} - {1'b0, PHASE_WIDTH'(s)};
    return t[PHASE_WIDTH] ? '0 : t[PHASE_WIDTH-1:0];
  endfunction

  assign hex        = hex_decode(rx_byte);
  assign to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (rx_valid && rx_byte == 8'h78) state_d = HEX;
      HEX: begin
        if (rx_valid) begin
          if (!hex[4])                            state_d = IDLE;
          else if (dig_q == DIG_W'(NDIG - 1))     state_d = COMMIT;
        end else if (to_expired) begin
          state_d = IDLE;
        end
      end
      COMMIT: state_d = IDLE;   // any byte arriving here is dropped
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    phase_d  = phase_q;
    shadow_d = shadow_q;
    gain_d   = gain_q;
    dig_d    = dig_q;
    to_d     = to_q;
    pu_d     = 1'b0;
    err_d    = 1'b0;
    ack_set  = 1'b0;
    ack_byte = ACK_K;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        ack_set = 1'b1;
        unique case (rx_byte)
          8'h30, 8'h31, 8'h32, 8'h33:
            gain_d = {{(GAIN_WIDTH-2){1'b0}}, rx_byte[1:0]};
          8'h61: begin phase_d = PHASE_WIDTH'(64'h02C6A19E88F1CFE2); pu_d = 1'b1; end
          8'h62: begin phase_d = PHASE_WIDTH'(64'h01AA60F8B8911654); pu_d = 1'b1; end
          8'h66: begin phase_d = PHASE_WIDTH'(64'h1DC38C076704516D); pu_d = 1'b1; end
          8'h67: begin phase_d = PHASE_WIDTH'(64'h1D60D923295482C6); pu_d = 1'b1; end
          8'h6D: begin phase_d = step_inc(phase_q, STEP_9K);  pu_d = 1'b1; end
          8'h6E: begin phase_d = step_dec(phase_q, STEP_9K);  pu_d = 1'b1; end
          8'h72: begin phase_d = step_inc(phase_q, STEP_1K);  pu_d = 1'b1; end
          8'h71: begin phase_d = step_dec(phase_q, STEP_1K);  pu_d = 1'b1; end
          8'h70: begin phase_d = step_inc(phase_q, STEP_100); pu_d = 1'b1; end
          8'h6F: begin phase_d = step_dec(phase_q, STEP_100); pu_d = 1'b1; end
          8'h78: begin
            shadow_d = '0;
            dig_d    = '0;
            to_d     = '0;
            ack_set  = 1'b0;   // ack comes at commit or abort
          end
          default: begin err_d = 1'b1; ack_byte = ACK_E; end
        endcase
      end
      HEX: begin
        if (rx_valid) begin
          to_d = '0;
          if (hex[4]) begin
            shadow_d = {shadow_q[PHASE_WIDTH-5:0], hex[3:0]};
            dig_d    = dig_q + 1'b1;
          end else begin
            err_d = 1'b1; ack_set = 1'b1; ack_byte = ACK_E;
          end
        end else if (to_expired) begin
          err_d = 1'b1; ack_set = 1'b1; ack_byte = ACK_E;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      COMMIT: begin
        phase_d = (shadow_q > PMAX) ? PMAX : shadow_q;
        pu_d    = 1'b1;
        ack_set = 1'b1;
      end
      default: ;
    endcase
    // Latest ack wins; a pending ack drains one cycle after tx_ready.
    txv_d = txv_q;
    txb_d = txb_q;
    if (ack_set) begin
      txv_d = 1'b1;
      txb_d = ack_byte;
    end else if (txv_q && tx_ready) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q  <= PHASE_WIDTH'(DEFAULT_PHASE_INC);
      shadow_q <= '0;
      gain_q   <= '0;
      dig_q    <= '0;
      to_q     <= '0;
      pu_q     <= 1'b0;
      err_q    <= 1'b0;
      txv_q    <= 1'b0;
      txb_q    <= ACK_K;
    end else begin
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      gain_q   <= gain_d;
      dig_q    <= dig_d;
      to_q     <= to_d;
      pu_q     <= pu_d;
      err_q    <= err_d;
      txv_q    <= txv_d;
      txb_q    <= txb_d;
    end
  end

  assign phase_increment = phase_q;
  assign phase_update    = pu_q;
  assign cic_gain        = gain_q;
  assign cmd_error       = err_q;
  assign tx_valid        = txv_q;
  assign tx_byte         = txb_q;
endmodule

// File: tb/tb_sdr_tuning_controller.sv
module tb_sdr_tuning_controller;
  localparam int T = 100;
  localparam logic [63:0] DEF  = 64'h02C6A19E88F1CFE2;
  localparam logic [63:0] PMAX = 64'h7FFFFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic [63:0] phase_increment;
  logic        phase_update;
  logic [7:0]  cic_gain;
  logic        cmd_error;

  int n_tests = 0;
  int n_fail  = 0;

  sdr_tuning_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .arst_n(arst_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .phase_increment(phase_increment), .phase_update(phase_update),
    .cic_gain(cic_gain), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Byte is sampled on the next edge; returns 1 time unit after that edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", phase_increment, DEF);
    check("rst_gain",  cic_gain, 0);
    check("rst_txv",   tx_valid, 0);
    check("rst_txb",   tx_byte, 8'h4B);
    check("rst_pu",    phase_update, 0);
    check("rst_err",   cmd_error, 0);
    arst_n = 1'b1;
    tick();

    // Preset 'b', ack held until tx_ready
    send(8'h62);
    check("b_phase", phase_increment, 64'h01AA60F8B8911654);
    check("b_pu",    phase_update, 1);
    check("b_txv",   tx_valid, 1);
    check("b_txb",   tx_byte, 8'h4B);
    tick();
    check("b_pu_off", phase_update, 0);
    tick();
    check("b_txv_hold", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    check("b_txv_drop", tx_valid, 0);

    // Hex entry of 1, then clamped decrements
    send(8'h78);
    send_str("0000000000000001");
    check("hex1_commit_wait", phase_increment, 64'h01AA60F8B8911654);
    tick();
    check("hex1_phase", phase_increment, 1);
    check("hex1_pu",    phase_update, 1);
    check("hex1_ack",   tx_byte, 8'h4B);
    tick();
    send(8'h6F);
    check("o_clamp",    phase_increment, 0);
    check("o_pu",       phase_update, 1);
    tick();
    send(8'h6E);
    check("n_clamp",    phase_increment, 0);
    check("n_pu",       phase_update, 1);
    tick();

    // Hex entry above Nyquist clamps; increment stays clamped
    send(8'h78);
    send_str("FFFFFFFFFFFFFFFF");
    tick();
    check("hexF_phase", phase_increment, PMAX);
    tick();
    send(8'h6D);
    check("m_clamp", phase_increment, PMAX);
    check("m_pu",    phase_update, 1);
    tick();

    // Abort on non-hex byte
    send(8'h78);
    send_str("12345");
    send(8'h7A);
    check("z_err",   cmd_error, 1);
    check("z_ack",   tx_byte, 8'h45);
    check("z_phase", phase_increment, PMAX);
    tick();
    check("z_err_off", cmd_error, 0);
    send(8'h61);
    check("a_phase", phase_increment, DEF);
    check("a_ack",   tx_byte, 8'h4B);
    check("a_err",   cmd_error, 0);
    tick();
    send(8'h72);
    check("r_step", phase_increment, 64'h02C76BC120FD7560);
    tick();
    send(8'h71);
    check("q_step", phase_increment, DEF);
    tick();

    // Inactivity timeout
    send(8'h78);
    send_str("123");
    repeat (T - 1) tick();
    check("to_before", cmd_error, 0);
    tick();
    check("to_err",   cmd_error, 1);
    check("to_ack",   tx_byte, 8'h45);
    check("to_phase", phase_increment, DEF);
    tick();

    // Digit arriving exactly at expiry is accepted
    send(8'h78);
    send_str("123");
    repeat (T - 1) tick();
    send(8'h34);
    check("to_race_err", cmd_error, 0);
    send_str("56789ABCDEF0");
    tick();
    check("to_race_phase", phase_increment, 64'h123456789ABCDEF0);
    tick();

    // CIC gain and invalid digit
    send(8'h32);
    check("gain2", cic_gain, 2);
    check("gain2_pu", phase_update, 0);
    tick();
    send(8'h37);
    check("gain7_err",  cmd_error, 1);
    check("gain7_keep", cic_gain, 2);
    check("gain7_ack",  tx_byte, 8'h45);
    tick();

    // Overlapping acks while transmitter is busy
    tx_ready = 1'b0;
    send(8'h31);
    check("gain1", cic_gain, 1);
    tick();
    send(8'h39);
    check("pend_txv", tx_valid, 1);
    check("pend_txb", tx_byte, 8'h45);
    tick();
    check("pend_hold", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    check("pend_drop", tx_valid, 0);

    // Reset mid-HEX
    tx_ready = 1'b0;
    send(8'h33);
    send(8'h78);
    send_str("12");
    arst_n = 1'b0;
    #1;
    check("mrst_phase", phase_increment, DEF);
    check("mrst_gain",  cic_gain, 0);
    check("mrst_txv",   tx_valid, 0);
    check("mrst_txb",   tx_byte, 8'h4B);
    tick();
    arst_n = 1'b1;
    tick();
    send(8'h32);
    check("mrst_idle_gain", cic_gain, 2);
    check("mrst_idle_err",  cmd_error, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
